sound_queue_generator: RTL and testbench

Next-generation square-wave tone generator with a DEPTH-entry note queue, parametrised field widths and a loop mode. The host pushes (duration, half-period) notes. The block plays them gaplessly in FIFO order, optionally recirculating them, and raises per-note and end-of-queue pulses. It sits between a melody/control FSM and the buzzer pin.

---
 rtl/sound_queue_generator_if.sv | 34 +++
 rtl/sound_queue_generator.sv | 132 +++++++++++++
 tb/tb_sound_queue_generator.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_queue_generator_if.sv
// Host-side note queue and tone status bundle.
// The host is the master, the tone generator the slave.
interface sound_queue_generator_if #(
  parameter int DUR_W = 16,
  parameter int HP_W  = 16,
  parameter int DEPTH = 8
);
  logic                   Push_i;
  logic [DUR_W-1:0]       Duration_ms_i;
  logic [HP_W-1:0]        HalfPeriod_us_i;
  logic                   Loop_i;
  logic                   Finish_i;
  logic                   Ready_o;
  logic                   Full_o;
  logic [$clog2(DEPTH):0] Count_o;
  logic                   SoundWave_o;
  logic                   Busy_o;
  logic                   NoteDone_o;
  logic                   Done_o;

  modport master (
    output Push_i, Duration_ms_i, HalfPeriod_us_i,
    output Loop_i, Finish_i,
    input  Ready_o, Full_o, Count_o, SoundWave_o,
    input  Busy_o, NoteDone_o, Done_o
  );

  modport slave (
    input  Push_i, Duration_ms_i, HalfPeriod_us_i,
    input  Loop_i, Finish_i,
    output Ready_o, Full_o, Count_o, SoundWave_o,
    output Busy_o, NoteDone_o, Done_o
  );
endinterface

// File: rtl/sound_queue_generator.sv
// Square-wave tone generator fed by a note FIFO,
// with gapless playback, loop writeback and abort.
module sound_queue_generator #(
  parameter int CLOCK_HZ = 2_000_000,
  parameter int DUR_W    = 16,
  parameter int HP_W     = 16,
  parameter int DEPTH    = 8
) (
  input logic Clock,
  input logic Reset,
  sound_queue_generator_if.slave q
);
  localparam int US_CYCLES = CLOCK_HZ / 1_000_000;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(US_CYCLES + 1);

  typedef enum logic {IDLE, PLAY} state_t;

  typedef struct packed {
    logic [DUR_W-1:0] dur;
    logic [HP_W-1:0]  hp;
  } note_t;

  state_t        state;
  note_t         mem [DEPTH];
  note_t         cur;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] pre;
  logic [9:0]    us_cnt;
  logic [DUR_W-1:0] ms_cnt;
  logic [HP_W-1:0]  hp_cnt;
  logic          wave;
  logic          done;

  logic full;
  logic empty;
  logic busy;
  logic us_tick;
  logic ms_tick;
  logic last;
  logic note_end;
  logic wb;
  logic push_ok;
  logic pop;
  logic wr_en;
  logic restart;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign busy    = (state == PLAY) || !empty;
  assign us_tick = pre == PW'(US_CYCLES - 1);
  assign ms_tick = us_tick && us_cnt == 10'd999;
  assign last    = (cur.dur == '0) ||
                   (ms_tick && ms_cnt == cur.dur - DUR_W'(1));
  assign note_end = (state == PLAY) && last;
  assign wb       = note_end && q.Loop_i && !full;
  assign push_ok  = q.Push_i && q.Ready_o;
  assign pop      = !empty && (state == IDLE || note_end);
  // A lone looping note replays in place instead of via the FIFO.
  assign restart  = wb && empty;
  assign wr_en    = push_ok || (wb && !empty);

  assign q.Ready_o     = !full && !wb && !q.Finish_i;
  assign q.Full_o      = full;
  assign q.Count_o     = count;
  assign q.SoundWave_o = wave;
  assign q.Busy_o      = busy;
  assign q.NoteDone_o  = note_end;
  assign q.Done_o      = done;

  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= wb ? cur
                        : {q.Duration_ms_i, q.HalfPeriod_us_i};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      cur    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pre    <= '0;
      us_cnt <= '0;
      ms_cnt <= '0;
      hp_cnt <= '0;
      wave   <= 1'b0;
      done   <= 1'b0;
    end else if (q.Finish_i) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wave   <= 1'b0;
      done   <= busy;
    end else begin
      done  <= note_end && empty && !wb;
      count <= count + CW'(wr_en) - CW'(pop);
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (pop || restart) begin
        if (pop) cur <= mem[rd_ptr];
        state  <= PLAY;
        pre    <= '0;
        us_cnt <= '0;
        ms_cnt <= '0;
        hp_cnt <= '0;
        wave   <= 1'b0;
      end else if (note_end) begin
        state <= IDLE;
        wave  <= 1'b0;
      end else if (state == PLAY) begin
        pre <= us_tick ? '0 : pre + PW'(1);
        if (us_tick) begin
          us_cnt <= ms_tick ? '0 : us_cnt + 10'd1;
          if (ms_tick) ms_cnt <= ms_cnt + DUR_W'(1);
          if (cur.hp != '0 && hp_cnt == cur.hp) begin
            hp_cnt <= '0;
            wave   <= ~wave;
          end else begin
            hp_cnt <= hp_cnt + HP_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sound_queue_generator.sv
// Bench for sound_queue_generator at 2 MHz:
// note-timing scoreboard, fill table, abort/loop/reset cases.
module tb_sound_queue_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sound_queue_generator_if #(
    .DUR_W(16), .HP_W(16), .DEPTH(8)
  ) q ();

  sound_queue_generator #(
    .CLOCK_HZ(2_000_000), .DUR_W(16),
    .HP_W(16), .DEPTH(8)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .q(q)
  );

  typedef struct {
    longint end_c;
    int     rises;
    longint last_rise;
  } exp_t;

  typedef struct {
    int dur;
    int hp;
    bit rdy_pre;
    int cnt_post;
    bit full_post;
  } vec_t;

  exp_t   exp_q[$];
  longint sched_end = -10;
  int     n_tests = 0;
  int     n_fail = 0;
  int     n_done = 0;
  longint last_done = -1;
  int     rises = 0;
  longint last_rise = -1;
  bit     prev_wave = 1'b0;
  int     max_cnt = 0;
  int     n_wb = 0;
  int     wb_rdy_hi = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic void add_note(int d, int h, longint e_edge);
    exp_t x;
    longint len, p, m, st;
    p = 0;
    len = (d == 0) ? 1 : longint'(d) * 2000;
    st = (e_edge > sched_end + 1) ? e_edge + 1 : sched_end + 1;
    x.end_c = st + len - 1;
    x.rises = 0;
    if (h != 0) begin
      p = longint'(h + 1) * 2;
      m = (len - 1) / p;
      x.rises = int'((m + 1) / 2);
    end
    x.last_rise = (x.rises > 0) ? st + (2 * x.rises - 1) * p : -1;
    sched_end = x.end_c;
    exp_q.push_back(x);
  endfunction

  // Monitor: inputs driven on the negedge are settled here.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (int'(q.Count_o) > max_cnt) max_cnt = int'(q.Count_o);
    if (q.SoundWave_o && !prev_wave) begin
      rises++;
      last_rise = cyc;
    end
    prev_wave = q.SoundWave_o;
    if (q.Done_o) begin
      n_done++;
      last_done = cyc;
    end
    if (q.NoteDone_o) begin
      if (q.Loop_i && !q.Full_o) begin
        n_wb++;
        if (q.Ready_o) wb_rdy_hi++;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_notedone", cyc, -1);
      end else begin
        e = exp_q.pop_front();
        chk("note_end_cycle", cyc, e.end_c);
        chk("note_rises", rises, e.rises);
        if (e.rises > 0) chk("note_last_rise", last_rise, e.last_rise);
      end
      rises = 0;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_note(int d, int h);
    q.Push_i = 1'b1;
    q.Duration_ms_i = 16'(d);
    q.HalfPeriod_us_i = 16'(h);
    chk("push_ready", q.Ready_o, 1);
    add_note(d, h, cyc + 1);
    step();
    q.Push_i = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    step();
    while (q.Busy_o && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", q.Busy_o, 0);
    repeat (2) step();
  endtask

  task automatic check_done(string nm, int d0);
    chk({nm, "_done_cnt"}, n_done - d0, 1);
    chk({nm, "_done_cyc"}, last_done, sched_end + 1);
    chk({nm, "_wave_idle"}, q.SoundWave_o, 0);
    chk({nm, "_busy_idle"}, q.Busy_o, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    int d0;
    longint st, k;

    for (int i = 0; i < 9; i++) begin
      vt[i].dur = 0;
      vt[i].hp = 10 * i + 5;
      vt[i].rdy_pre = (i < 8);
      vt[i].cnt_post = (i < 8) ? i + 1 : 8;
      vt[i].full_post = (i >= 7);
    end

    q.Push_i = 1'b0;
    q.Duration_ms_i = '0;
    q.HalfPeriod_us_i = '0;
    q.Loop_i = 1'b0;
    q.Finish_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_wave", q.SoundWave_o, 0);
    chk("rst_busy", q.Busy_o, 0);
    chk("rst_notedone", q.NoteDone_o, 0);
    chk("rst_done", q.Done_o, 0);
    chk("rst_count", q.Count_o, 0);
    chk("rst_full", q.Full_o, 0);
    chk("rst_ready", q.Ready_o, 1);

    // 1: single note
    d0 = n_done;
    push_note(1, 9);
    wait_idle(5000);
    check_done("t1", d0);

    // 2: three gapless notes
    d0 = n_done;
    max_cnt = 0;
    push_note(1, 9);
    push_note(2, 0);
    push_note(3, 49);
    wait_idle(15000);
    chk("t2_max_count", max_cnt, 2);
    chk("t2_queue_drained", exp_q.size(), 0);
    check_done("t2", d0);

    // 3: zero-length middle note
    d0 = n_done;
    push_note(1, 9);
    push_note(0, 99);
    push_note(1, 49);
    wait_idle(6000);
    chk("t3_queue_drained", exp_q.size(), 0);
    check_done("t3", d0);

    // 4: fill the queue behind a long note
    d0 = n_done;
    push_note(10, 4);
    step();
    chk("t4_playing_count", q.Count_o, 0);
    for (int i = 0; i < 9; i++) begin
      q.Push_i = 1'b1;
      q.Duration_ms_i = 16'(vt[i].dur);
      q.HalfPeriod_us_i = 16'(vt[i].hp);
      chk("t4_ready_pre", q.Ready_o, vt[i].rdy_pre);
      if (vt[i].rdy_pre) add_note(vt[i].dur, vt[i].hp, cyc + 1);
      step();
      chk("t4_count", q.Count_o, vt[i].cnt_post);
      chk("t4_full", q.Full_o, vt[i].full_post);
    end
    q.Push_i = 1'b0;
    step();
    chk("t4_count_hold", q.Count_o, 8);
    chk("t4_ready_full", q.Ready_o, 0);
    wait_idle(25000);
    chk("t4_queue_drained", exp_q.size(), 0);
    check_done("t4", d0);

    // 5: abort mid-note
    d0 = n_done;
    k = cyc;
    push_note(10, 499);
    push_note(1, 9);
    push_note(1, 9);
    st = k + 2;
    while (cyc < st + 12499) step();
    chk("t5_count_pre", q.Count_o, 2);
    chk("t5_busy_pre", q.Busy_o, 1);
    q.Finish_i = 1'b1;
    step();
    q.Finish_i = 1'b0;
    exp_q.delete();
    sched_end = -10;
    rises = 0;
    chk("t5_wave", q.SoundWave_o, 0);
    chk("t5_count", q.Count_o, 0);
    chk("t5_busy", q.Busy_o, 0);
    chk("t5_done", q.Done_o, 1);
    step();
    chk("t5_done_pulse", q.Done_o, 0);
    repeat (100) step();
    chk("t5_done_cnt", n_done - d0, 1);

    // Finish while idle does nothing
    d0 = n_done;
    q.Finish_i = 1'b1;
    step();
    q.Finish_i = 1'b0;
    repeat (3) step();
    chk("idle_finish_done", n_done - d0, 0);

    // 6: loop two notes, then release
    d0 = n_done;
    n_wb = 0;
    wb_rdy_hi = 0;
    q.Loop_i = 1'b1;
    k = cyc;
    push_note(1, 9);
    push_note(1, 49);
    for (int i = 0; i < 2; i++) begin
      add_note(1, 9, 0);
      add_note(1, 49, 0);
    end
    add_note(1, 9, 0);
    st = k + 2;
    while (cyc < st + 10100) step();
    chk("t6_no_done_loop", n_done - d0, 0);
    chk("t6_count_loop", q.Count_o, 1);
    q.Loop_i = 1'b0;
    wait_idle(6000);
    chk("t6_queue_drained", exp_q.size(), 0);
    chk("t6_wb_cycles", n_wb, 5);
    chk("t6_wb_ready_hi", wb_rdy_hi, 0);
    check_done("t6", d0);

    // 6b: reset mid-note while looping
    d0 = n_done;
    q.Loop_i = 1'b1;
    k = cyc;
    push_note(1, 9);
    while (cyc < k + 2 + 500) step();
    chk("t6b_wave_pre", q.SoundWave_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.Loop_i = 1'b0;
    exp_q.delete();
    sched_end = -10;
    rises = 0;
    chk("t6b_wave", q.SoundWave_o, 0);
    chk("t6b_busy", q.Busy_o, 0);
    chk("t6b_notedone", q.NoteDone_o, 0);
    chk("t6b_done", q.Done_o, 0);
    chk("t6b_count", q.Count_o, 0);
    chk("t6b_full", q.Full_o, 0);
    repeat (30) step();
    chk("t6b_no_done", n_done - d0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
